// File: rtl/dcache_meta_pkg.sv
// Shared definitions for the data-cache metadata array.
// Holds default geometry, coherence-state encoding, the per-way metadata
// entry layout and the init/run state encoding.
package dcache_meta_pkg;

   localparam int unsigned N_SETS = 64;
   localparam int unsigned N_WAYS = 8;
   localparam int unsigned TAG_W  = 20;
   localparam int unsigned IDX_W  = $clog2(N_SETS);

   // Coherence-state encoding
   localparam logic [1:0] NOTHING = 2'd0;
   localparam logic [1:0] BRANCH  = 2'd1;
   localparam logic [1:0] TRUNK   = 2'd2;
   localparam logic [1:0] DIRTY   = 2'd3;

   typedef struct packed {
      logic [1:0]       coh_state;
      logic [TAG_W-1:0] tag;
   } meta_t;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } meta_state_e;

endpackage

// File: rtl/dcache_meta_array_init_seq.sv
// meta_init_seq: post-reset sweep sequencer for the metadata array.
// Walks rst_cnt over every set once, then parks in RUN until the next reset.
// Ports:
//   clock, reset  - clock and synchronous active-high reset
//   init_active   - high while the sweep is clearing set init_idx
//   init_idx      - set being cleared this cycle
//   done          - high once every set has been cleared
module meta_init_seq
   import dcache_meta_pkg::*;
#(
   parameter int unsigned N_SETS = dcache_meta_pkg::N_SETS
) (
   input  logic                      clock,
   input  logic                      reset,
   output logic                      init_active,
   output logic [$clog2(N_SETS)-1:0] init_idx,
   output logic                      done
);

   localparam int unsigned IDX_W = $clog2(N_SETS);

   meta_state_e      state_q, state_d;
   logic [IDX_W-1:0] rst_cnt_q, rst_cnt_d;

   // State and sweep counter registers
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= INIT;
         rst_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         rst_cnt_q <= rst_cnt_d;
      end
   end

   // Next state and decoded outputs
   always_comb begin
      state_d     = state_q;
      rst_cnt_d   = rst_cnt_q;
      init_active = 1'b0;
      done        = 1'b0;
      init_idx    = rst_cnt_q;
      case (state_q)
         INIT: begin
            init_active = 1'b1;
            rst_cnt_d   = IDX_W'(rst_cnt_q + 1'b1);
            if (rst_cnt_q == IDX_W'(N_SETS - 1)) begin
               state_d = RUN;
            end
         end
         RUN: begin
            done = 1'b1;
         end
         default: begin
            state_d = INIT;
         end
      endcase
   end

endmodule

// File: rtl/dcache_meta_array.sv
// dcache_meta_array: storage endpoint of the data-cache metadata path.
// Accepts metadata writes (set, way mask, coherence state, tag) and serves
// whole-set reads with a one-cycle registered response. Writes win over reads.
// Optional macro META_INIT_EN: when defined, every set is cleared to
// coh_state 0 / tag 0 after reset before any traffic is accepted; when
// undefined, traffic is accepted immediately and contents are undefined
// until written.
// Ports:
//   clock, reset            - clock and synchronous active-high reset
//   io_write_*              - ready/valid metadata write request
//   io_read_*               - ready/valid set read request
//   io_resp_valid           - response strobe, one cycle after read accept
//   io_resp_coh_state/tag   - all ways of the read set, way w in slice w
//   io_init_done            - array ready for traffic
module dcache_meta_array
   import dcache_meta_pkg::*;
#(
   parameter int unsigned N_SETS = dcache_meta_pkg::N_SETS,
   parameter int unsigned N_WAYS = dcache_meta_pkg::N_WAYS
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          io_write_valid,
   output logic                          io_write_ready,
   input  logic [$clog2(N_SETS)-1:0]     io_write_bits_idx,
   input  logic [N_WAYS-1:0]             io_write_bits_way_en,
   input  logic [1:0]                    io_write_bits_data_coh_state,
   input  logic [TAG_W-1:0]              io_write_bits_data_tag,
   input  logic                          io_read_valid,
   output logic                          io_read_ready,
   input  logic [$clog2(N_SETS)-1:0]     io_read_bits_idx,
   output logic                          io_resp_valid,
   output logic [2*N_WAYS-1:0]           io_resp_coh_state,
   output logic [TAG_W*N_WAYS-1:0]       io_resp_tag,
   output logic                          io_init_done
);

   localparam int unsigned IDX_W = $clog2(N_SETS);

   meta_t            meta_q [N_SETS][N_WAYS];
   logic             init_active;
   logic [IDX_W-1:0] init_idx;
   logic             seq_done;
   logic             run_c;
   logic             write_fire;
   logic             read_fire;
   meta_t            wr_meta;

`ifdef META_INIT_EN
   meta_init_seq #(
      .N_SETS (N_SETS)
   ) u_init_seq (
      .clock       (clock),
      .reset       (reset),
      .init_active (init_active),
      .init_idx    (init_idx),
      .done        (seq_done)
   );
`else
   assign init_active = 1'b0;
   assign init_idx    = '0;
   assign seq_done    = 1'b1;
`endif

   // Traffic is blocked while reset is held and until the sweep finishes
   assign run_c          = seq_done & ~reset;
   assign io_init_done   = run_c;
   assign io_write_ready = run_c;
   assign io_read_ready  = run_c & ~io_write_valid;

   assign write_fire = io_write_valid & io_write_ready;
   assign read_fire  = io_read_valid & io_read_ready;
   assign wr_meta    = '{coh_state: io_write_bits_data_coh_state,
                         tag:       io_write_bits_data_tag};

   // Metadata storage: sweep clears a whole set, writes update masked ways
   always_ff @(posedge clock) begin
      for (int w = 0; w < int'(N_WAYS); w++) begin
         if (init_active) begin
            meta_q[init_idx][w] <= '0;
         end else if (write_fire && io_write_bits_way_en[w]) begin
            meta_q[io_write_bits_idx][w] <= wr_meta;
         end
      end
   end

   // Read response registers; data holds when no read was accepted
   always_ff @(posedge clock) begin
      if (reset) begin
         io_resp_valid     <= 1'b0;
         io_resp_coh_state <= '0;
         io_resp_tag       <= '0;
      end else begin
         io_resp_valid <= read_fire;
         if (read_fire) begin
            for (int w = 0; w < int'(N_WAYS); w++) begin
               io_resp_coh_state[2*w +: 2]  <= meta_q[io_read_bits_idx][w].coh_state;
               io_resp_tag[TAG_W*w +: TAG_W] <= meta_q[io_read_bits_idx][w].tag;
            end
         end
      end
   end

endmodule
